// File: rtl/mem_pkg.sv
// Shared types for the M-stage data memory: FSM states, byte-enable type,
// and the upper bound on access latency.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  localparam int MAX_LATENCY = 7;

  typedef logic [3:0] byte_en_t;

endpackage

// File: rtl/bram_be.sv
// Synchronous single-port word RAM with per-byte write enables.
// The read port is registered and returns the pre-write word (read-before-write).
module bram_be
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  byte_en_t          be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Only the output register clears; it holds its value between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= r_mem[addr];
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// M-stage data memory: fixed-latency load/store access with a pipeline stall.
// The FSM walks IDLE -> (WAIT) -> DONE; the array is read and written on the edge entering DONE.
module dmem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  byte_en_t    byteEnable,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        stall,
  output mem_state_t  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_stage: LATENCY must be in 1..%0d", MAX_LATENCY);
  end
  if ((1 << AW) != DEPTH_WORDS) begin : g_bad_depth
    $error("dmem_stage: DEPTH_WORDS must be a power of two");
  end

  mem_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  logic            w_req;
  logic            w_last;
  logic            w_commit;
  logic [AW-1:0]   w_index;
  logic            w_unused;

  assign w_req    = MemWriteM | MemtoRegM;
  assign w_last   = (r_cnt <= CW'(1));
  assign w_index  = ALUResultM[AW+1:2];
  assign w_unused = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

  // Gated by reset so an aborted access can never reach the array,
  // even while the frozen pipeline keeps the request asserted.
  always_comb begin
    w_commit = 1'b0;
    stall    = 1'b0;
    if (reset) begin
      w_commit = ((r_state == IDLE) && w_req && (LATENCY == 1)) ||
                 ((r_state == WAIT) && w_last);
      stall    = (r_state == WAIT) || ((r_state == IDLE) && w_req);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dbg_state = r_state;

  bram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_bram (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_commit),
    .we    (MemWriteM),
    .be    (byteEnable),
    .addr  (w_index),
    .wdata (WriteDataM),
    .rdata (ReadDataM)
  );

endmodule
